// File: rtl/bpa_issue_ctrl.sv
// Issue/collect stage around the block-pipelined adder: credit-gated intake, latency-matched tag line, FWFT result FIFO.
// Optional statistics counters are enabled by defining BPA_ISSUE_STATS_EN.
module bpa_issue_ctrl #(
  parameter int N     = 16,
  parameter int M     = 4,
  parameter int LAT   = 4,
  parameter int TW    = 4,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_a,
  input  logic [N-1:0]  in_b,
  input  logic [TW-1:0] in_tag,
  output logic [N-1:0]  add_a,
  output logic [N-1:0]  add_b,
  input  logic [N-1:0]  add_sum,
  input  logic          add_cout,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_sum,
  output logic          out_cout,
  output logic [TW-1:0] out_tag
`ifdef BPA_ISSUE_STATS_EN
  ,
  output logic [31:0]   stat_issued,
  output logic [31:0]   stat_stall
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = N + 1 + TW;

  logic [CW-1:0] credits_r;
  logic          accept_s;
  logic          pop_s;
  logic [N-1:0]  add_a_r;
  logic [N-1:0]  add_b_r;
  logic          vld_r [0:LAT];
  logic [TW-1:0] tag_r [0:LAT];
  logic [EW-1:0] mem_r [0:DEPTH-1];
  logic [PW:0]   wr_ptr_r;
  logic [PW:0]   rd_ptr_r;
  logic [PW:0]   wr_nxt_s;
  logic [PW:0]   rd_nxt_s;
  logic          wr_s;
  logic          full_s;
  logic [EW-1:0] wdata_s;
  logic [EW-1:0] head_nxt_s;
  logic          out_valid_r;
  logic [EW-1:0] head_r;

  assign in_ready = (credits_r != {CW{1'b0}});
  assign accept_s = in_valid && in_ready;
  assign pop_s    = out_valid_r && out_ready;
  assign wr_s     = vld_r[LAT];
  assign wdata_s  = {add_sum, add_cout, tag_r[LAT]};
  assign full_s   = (wr_ptr_r[PW] != rd_ptr_r[PW]) && (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]);

  // Credit counter: one slot reserved per accept, returned per pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits_r <= CW'(DEPTH);
    end else begin
      case ({accept_s, pop_s})
        2'b10:   credits_r <= credits_r - {{(CW-1){1'b0}}, 1'b1};
        2'b01:   credits_r <= credits_r + {{(CW-1){1'b0}}, 1'b1};
        default: credits_r <= credits_r;
      endcase
    end
  end

  // Operand issue register; zeros when idle so nothing stale is replayed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_a_r <= {N{1'b0}};
      add_b_r <= {N{1'b0}};
    end else if (accept_s) begin
      add_a_r <= in_a;
      add_b_r <= in_b;
    end else begin
      add_a_r <= {N{1'b0}};
      add_b_r <= {N{1'b0}};
    end
  end

  assign add_a = add_a_r;
  assign add_b = add_b_r;

  // Valid/tag delay line; stage LAT lines up with the adder result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= LAT; i++) begin
        vld_r[i] <= 1'b0;
        tag_r[i] <= {TW{1'b0}};
      end
    end else begin
      vld_r[0] <= accept_s;
      tag_r[0] <= accept_s ? in_tag : {TW{1'b0}};
      for (int i = 1; i <= LAT; i++) begin
        vld_r[i] <= vld_r[i-1];
        tag_r[i] <= tag_r[i-1];
      end
    end
  end

  // FIFO storage; contents are only meaningful between the pointers
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_r[wr_ptr_r[PW-1:0]] <= wdata_s;
    end
  end

  // Next pointers and next head; a head that is being written this cycle bypasses the memory
  always_comb begin
    wr_nxt_s   = wr_s  ? wr_ptr_r + {{PW{1'b0}}, 1'b1} : wr_ptr_r;
    rd_nxt_s   = pop_s ? rd_ptr_r + {{PW{1'b0}}, 1'b1} : rd_ptr_r;
    head_nxt_s = {EW{1'b0}};
    if (rd_nxt_s == wr_ptr_r) begin
      head_nxt_s = wdata_s;
    end else begin
      head_nxt_s = mem_r[rd_nxt_s[PW-1:0]];
    end
  end

  // Pointers plus registered FWFT head; head holds its last value while empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r    <= {(PW+1){1'b0}};
      rd_ptr_r    <= {(PW+1){1'b0}};
      out_valid_r <= 1'b0;
      head_r      <= {EW{1'b0}};
    end else begin
      wr_ptr_r <= wr_nxt_s;
      rd_ptr_r <= rd_nxt_s;
      if (rd_nxt_s != wr_nxt_s) begin
        out_valid_r <= 1'b1;
        head_r      <= head_nxt_s;
      end else begin
        out_valid_r <= 1'b0;
        head_r      <= head_r;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign out_sum   = head_r[EW-1 -: N];
  assign out_cout  = head_r[TW];
  assign out_tag   = head_r[TW-1:0];

`ifdef BPA_ISSUE_STATS_EN
  logic [31:0] stat_issued_r;
  logic [31:0] stat_stall_r;

  // Free-running accept and stall counters, wrapping at 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_issued_r <= 32'd0;
      stat_stall_r  <= 32'd0;
    end else begin
      stat_issued_r <= accept_s ? stat_issued_r + 32'd1 : stat_issued_r;
      stat_stall_r  <= (in_valid && !in_ready) ? stat_stall_r + 32'd1 : stat_stall_r;
    end
  end

  assign stat_issued = stat_issued_r;
  assign stat_stall  = stat_stall_r;
`endif

  bpa_issue_ctrl_chk #(.N(N), .M(M), .LAT(LAT)) u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .wr    (wr_s),
    .full  (full_s)
  );

endmodule

module bpa_issue_ctrl_chk #(
  parameter int N   = 16,
  parameter int M   = 4,
  parameter int LAT = 4
) (
  input logic clk,
  input logic rst_n,
  input logic wr,
  input logic full
);

  // Every issue was pre-credited a slot, so a write can never find the FIFO full
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(wr && full));
  a_lat_match:   assert property (@(posedge clk) disable iff (!rst_n) LAT == N / M);

endmodule

// File: tb/tb_bpa_issue_ctrl.sv
// Randomised scoreboard bench for bpa_issue_ctrl with a behavioural adder pipeline model.
module tb_bpa_issue_ctrl;
  localparam int N = 16, M = 4, LAT = 4, TW = 4, DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, add_cout, out_valid, out_ready, out_cout;
  logic [N-1:0] in_a, in_b, add_a, add_b, add_sum, out_sum;
  logic [TW-1:0] in_tag, out_tag;
`ifdef BPA_ISSUE_STATS_EN
  logic [31:0] stat_issued, stat_stall;
`endif

  bpa_issue_ctrl #(.N(N), .M(M), .LAT(LAT), .TW(TW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .add_a(add_a), .add_b(add_b),
    .add_sum(add_sum), .add_cout(add_cout), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout), .out_tag(out_tag)
`ifdef BPA_ISSUE_STATS_EN
    , .stat_issued(stat_issued), .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  // Adder stand-in: full-width sum of the operands seen LAT cycles earlier
  logic [N:0] pipe [0:LAT-1];
  initial for (int i = 0; i < LAT; i++) pipe[i] = '0;
  always @(posedge clk) begin
    for (int i = LAT-1; i > 0; i--) pipe[i] <= pipe[i-1];
    pipe[0] <= {1'b0, add_a} + {1'b0, add_b};
  end
  assign add_sum  = pipe[LAT-1][N-1:0];
  assign add_cout = pipe[LAT-1][N];

  typedef struct {
    logic [N-1:0]  sum;
    logic          cout;
    logic [TW-1:0] tag;
    int            acc;
  } exp_t;

  exp_t q[$];
  int tests = 0, fails = 0, cyc = 0, credits_m = DEPTH, n_acc = 0;
  int issued_m = 0, stall_m = 0;
  logic prev_ov = 1'b0, prev_acc = 1'b0;
  logic [N-1:0] prev_a = '0, prev_b = '0, last_sum = '0;
  logic last_cout = 1'b0;
  logic [TW-1:0] last_tag = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor/scoreboard: one evaluation per cycle, on the falling edge
  always @(negedge clk) begin
    exp_t e;
    logic [N:0] s;
    if (!rst_n) begin
      q.delete();
      credits_m = DEPTH; prev_ov = 1'b0; prev_acc = 1'b0;
      last_sum = '0; last_cout = 1'b0; last_tag = '0;
      issued_m = 0; stall_m = 0;
    end else begin
      chk("in_ready", in_ready, 64'(credits_m != 0));
      chk("add_a", add_a, prev_acc ? prev_a : '0);
      chk("add_b", add_b, prev_acc ? prev_b : '0);
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_out", out_valid, 1'b0);
        end else begin
          chk("out_sum", out_sum, q[0].sum);
          chk("out_cout", out_cout, q[0].cout);
          chk("out_tag", out_tag, q[0].tag);
          if (!prev_ov) chk("latency", 64'(cyc - q[0].acc), 64'(LAT + 2));
          if (out_ready) begin
            last_sum = q[0].sum; last_cout = q[0].cout; last_tag = q[0].tag;
            void'(q.pop_front());
            credits_m++;
          end
        end
      end else begin
        chk("hold_sum", out_sum, last_sum);
        chk("hold_cout", out_cout, last_cout);
        chk("hold_tag", out_tag, last_tag);
      end
      if (in_valid && in_ready) begin
        s = {1'b0, in_a} + {1'b0, in_b};
        e.sum = s[N-1:0]; e.cout = s[N]; e.tag = in_tag; e.acc = cyc;
        q.push_back(e);
        credits_m--; n_acc++; issued_m++;
      end
      if (in_valid && !in_ready) stall_m++;
      prev_ov  = out_valid;
      prev_acc = in_valid && in_ready;
      prev_a   = in_a;
      prev_b   = in_b;
    end
  end

  task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic [TW-1:0] t);
    logic acc;
    int k = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_tag = t;
    do begin
      @(negedge clk) acc = in_ready;
      @(posedge clk) #1;
      k++;
    end while (!acc && k < 300);
    if (!acc) chk("send_timeout", acc, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [N-1:0] s, input logic c, input logic [TW-1:0] t);
    int k = 0;
    @(negedge clk);
    while (!out_valid && k < 50) begin @(negedge clk); k++; end
    chk({name, "_valid"}, out_valid, 1'b1);
    chk({name, "_sum"}, out_sum, s);
    chk({name, "_cout"}, out_cout, c);
    chk({name, "_tag"}, out_tag, t);
  endtask

  task automatic wait_drain();
    int k = 0;
    while ((q.size() != 0 || out_valid) && k < 300) begin @(negedge clk); k++; end
    chk("drain", 64'(q.size()), 64'd0);
    @(posedge clk) #1;
  endtask

  initial begin
    int base;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_tag = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_sum", out_sum, '0);
    @(posedge clk) #1;

    out_ready = 1'b1;
    send(16'h00F8, 16'd8, 4'd1);
    expect_out("single", 16'h0100, 1'b0, 4'd1);
    send(16'hFFFF, 16'd1, 4'd2);
    expect_out("carry", 16'h0000, 1'b1, 4'd2);
    wait_drain();

    send(16'd3, 16'd1, 4'd3);
    send(16'd5, 16'd2, 4'd4);
    send(16'd100, 16'd100, 4'd5);
    expect_out("b2b0", 16'd4, 1'b0, 4'd3);
    expect_out("b2b1", 16'd7, 1'b0, 4'd4);
    expect_out("b2b2", 16'd200, 1'b0, 4'd5);
    wait_drain();

    // Reset while three ops are in flight; scoreboard is cleared, any result is unexpected
    send(16'd10, 16'd20, 4'd6);
    send(16'd30, 16'd40, 4'd7);
    send(16'd50, 16'd60, 4'd8);
    rst_n = 1'b0;
    @(posedge clk) #1 rst_n = 1'b1;
    @(negedge clk) chk("rst_mid_in_ready", in_ready, 1'b1);
    repeat (12) @(posedge clk);
    #1;

    out_ready = 1'b0;
    base = n_acc;
    fork
      for (int i = 0; i < 10; i++) send(16'($urandom), 16'($urandom), 4'(i));
      begin
        repeat (20) @(posedge clk);
        #1;
        chk("bp_accepted", 64'(n_acc - base), 64'd8);
        chk("bp_in_ready", in_ready, 1'b0);
        out_ready = 1'b1;
      end
    join
    wait_drain();
`ifdef BPA_ISSUE_STATS_EN
    chk("stat_issued", stat_issued, 32'd10);
    chk("stat_stall", stat_stall, 32'(stall_m));
`endif

    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) send(16'(i * 7), 16'(i), 4'(i));
    repeat (12) @(posedge clk);
    #1;
    chk("sim_full", in_ready, 1'b0);
    in_valid = 1'b1; in_a = 16'h1234; in_b = 16'h0101; in_tag = 4'hA; out_ready = 1'b1;
    @(negedge clk) chk("sim_no_accept", in_ready, 1'b0);
    @(posedge clk) #1 out_ready = 1'b0;
    @(negedge clk) chk("sim_accept_next", in_ready, 1'b1);
    @(posedge clk) #1 in_valid = 1'b0;
    @(negedge clk) chk("sim_credits_zero", in_ready, 1'b0);
    @(posedge clk) #1 out_ready = 1'b1;
    wait_drain();

    repeat (400) begin
      in_valid  = 1'($urandom);
      in_a      = 16'($urandom);
      in_b      = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      in_tag    = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk) #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    wait_drain();
    chk("final_in_ready", in_ready, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bpa_issue_ctrl.md
Name: bpa_issue_ctrl

Overview:
- Issue/collect stage wrapped around the block-pipelined adder (BPA_N, N-bit, M-bit blocks).
- Accepts tagged operand pairs over a valid/ready handshake and drives registered operands into the adder's A/B inputs.
- Tracks in-flight operations with a valid/tag delay line matched to the adder latency, and captures Sum/Cout into an output FIFO.
- The adder pipeline cannot stall, so a credit counter guarantees a FIFO slot for every issued operation.

Parameters:
- N, 16, operand/sum width; must match the adder.
- M, 4, adder block width; informational only.
- LAT, 4, adder latency: operands present on add_a/add_b in cycle k give add_sum/add_cout valid in cycle k+LAT. Set to N/M.
- TW, 4, tag width.
- DEPTH, 8, output FIFO depth; power of two, ≥2.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  stage can accept a pair
- in_a  in  N  operand A
- in_b  in  N  operand B
- in_tag  in  TW  user tag, returned with the result
- add_a  out  N  to adder A
- add_b  out  N  to adder B
- add_sum  in  N  from adder Sum
- add_cout  in  1  from adder Cout
- out_valid  out  1  result available (FIFO head)
- out_ready  in  1  consumer pops the head
- out_sum  out  N  result sum
- out_cout  out  1  result carry-out
- out_tag  out  TW  tag of the result

Behaviour:
- Reset (async assert, sync release):
  - add_a = add_b = 0; delay line cleared; FIFO empty.
  - out_valid = 0; out_sum, out_cout, out_tag = 0; credits = DEPTH; in_ready = 1.
- Credits:
  - in_ready = (credits != 0), a pure function of registered state.
  - Accept = in_valid && in_ready. Pop = out_valid && out_ready.
  - Accept only: credits−1. Pop only: credits+1. Both together: unchanged.
  - Invariant: credits + in-flight + FIFO occupancy == DEPTH.
- Issue:
  - On accept at the end of cycle c0, add_a/add_b register in_a/in_b, visible in cycle c1.
  - With no accept, add_a/add_b load 0 (no stale replay).
  - Stage 0 of the delay line loads {1, in_tag}, otherwise {0, x}.
- Delay line:
  - LAT+1 stages of {vld, tag}, shifting every cycle, aligned so stage LAT is valid in cycle c1+LAT.
  - In that cycle, the FIFO writes {add_sum, add_cout, tag} at the clock edge.
  - out_valid rises in cycle c0+LAT+2, so handshake-to-out_valid = LAT+2 cycles (6 by default).
- FIFO:
  - First-word-fall-through; out_* show the head whenever out_valid = 1, and are held at their last value when the FIFO is empty.
  - Write and pop in the same cycle are both honoured; occupancy is unchanged.
  - Overflow is impossible by the credit rule. A write while full is a design error, flagged by a simulation-only assertion.
- Throughput: one accept per cycle sustained while credits > 0; with out_ready held high, steady-state in_ready stays 1.
- Full: credits == 0 → in_ready = 0. A pop in that cycle raises in_ready in the next cycle, not the same cycle.
- Wrap-around: FIFO pointers are log2(DEPTH)+1 bits; full when the MSBs differ and the rest match.
- Arithmetic: no width change; sum and cout are passed through from the adder unmodified.
- Reset mid-operation: in-flight entries and FIFO contents are discarded. The adder keeps computing, but its outputs are ignored because the delay line is cleared.

Optional Feature:
- Macro BPA_ISSUE_STATS_EN.
- Defined:
  - Adds outputs stat_issued[31:0] (count of accepts) and stat_stall[31:0] (count of cycles with in_valid && !in_ready).
  - Both reset to 0 and wrap at 2^32.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Single op: in_a=16'h00F8, in_b=8, tag=1, accepted in cycle 0 → out_valid in cycle 6 with out_sum=16'h0100, out_cout=0, out_tag=1.
- Carry: in_a=16'hFFFF, in_b=1, tag=2 → out_sum=0, out_cout=1, out_tag=2.
- Back-to-back: pairs (3,1), (5,2), (100,100), tags 3,4,5, on consecutive cycles, out_ready=1 → sums 4, 7, 200 in order on cycles 6, 7, 8; in_ready stays 1 throughout.
- Backpressure: out_ready=0, 10 pairs offered continuously → exactly 8 accepted, then in_ready=0. Raise out_ready → 8 results out in order, then the remaining 2.
- Simultaneous: credits=0, pop and in_valid both high in the same cycle → no accept that cycle; accept next cycle; credits return to 0.
- Reset mid-flight: 3 ops issued, rst_n low for 1 cycle in cycle 3 → no out_valid ever produced for them; credits=8; in_ready=1 after release.
- Stats (BPA_ISSUE_STATS_EN defined): run the backpressure case → stat_issued=10; stat_stall equals the number of cycles in_valid was blocked.
